// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction-fetch stage feeding the IF/ID pipeline register. Owns the
// program counter, runs a request/acknowledge handshake with a
// variable-latency instruction memory, presents each fetched word with its
// PC+4, and discards any in-flight fetch made stale by an ID-stage redirect.
//
// Ports
//   clk_i            clock, rising edge
//   rst_i            asynchronous active-low reset
//   start_i          fetch enable; no new request is issued while low
//   hd_i             hazard stall from ID; holds the presented instruction
//   stall_i          global pipeline stall; freezes PC and presented outputs
//   redirect_i       branch taken / jump from ID
//   redirect_addr_i  redirect target (bits [1:0] ignored)
//   imem_req_o       instruction-memory request (high in FETCH and DISCARD)
//   imem_addr_o      address of the outstanding request
//   imem_ack_i       one-cycle response pulse
//   imem_data_i      returned instruction word, valid with imem_ack_i
//   instr_o          instruction to IF/ID
//   addr_o           PC+4 of instr_o
//   fetch_stall_o    high while no valid instruction is presented
// -----------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        hd_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_addr_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] instr_o,
    output logic [31:0] addr_o,
    output logic        fetch_stall_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DISCARD,
        S_READY
    } state_t;

    // The low PC bits are forced to zero even if the parameter is misaligned.
    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_req_addr;
    logic        r_req;
    logic [31:0] r_instr;
    logic [31:0] r_addr;
    logic        r_fetch_stall;

    logic [31:0] w_target;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_redir;

    assign w_target   = {redirect_addr_i[31:2], 2'b00};
    assign w_pc_plus4 = r_pc + 32'd4;          // wraps naturally at 2^32
    assign w_pc_redir = redirect_i ? w_target : r_pc;

    assign imem_req_o    = r_req;
    assign imem_addr_o   = r_req_addr;
    assign instr_o       = r_instr;
    assign addr_o        = r_addr;
    assign fetch_stall_o = r_fetch_stall;

    // NOTE: every state register, including the presented instruction and
    // address, is reset because they drive module outputs with defined reset
    // values; there is no memory array here that could skip reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC_ALIGNED;
            r_req_addr    <= RESET_PC_ALIGNED;
            r_req         <= 1'b0;
            r_instr       <= 32'h0;
            r_addr        <= 32'h0;
            r_fetch_stall <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch below
            // reads the pre-edge values of r_pc / r_state regardless of order.
            case (r_state)
                S_IDLE: begin
                    // A redirect while idle still retargets the next fetch.
                    r_pc <= w_pc_redir;
                    if (start_i) begin
                        r_state    <= S_FETCH;
                        r_req      <= 1'b1;
                        r_req_addr <= w_pc_redir;
                    end
                end

                S_FETCH: begin
                    if (imem_ack_i) begin
                        if (redirect_i) begin
                            // Returned word is on the wrong path: drop it and
                            // issue the target on the next cycle.
                            r_pc       <= w_target;
                            r_req_addr <= w_target;
                        end else begin
                            r_instr       <= imem_data_i;
                            r_addr        <= w_pc_plus4;
                            r_req         <= 1'b0;
                            r_fetch_stall <= 1'b0;
                            r_state       <= S_READY;
                        end
                    end else if (redirect_i) begin
                        // The old request must stay up with its old address
                        // until memory answers it.
                        r_pc    <= w_target;
                        r_state <= S_DISCARD;
                    end
                end

                S_DISCARD: begin
                    r_pc <= w_pc_redir;
                    if (imem_ack_i) begin
                        r_req_addr <= w_pc_redir;
                        r_state    <= S_FETCH;
                    end
                end

                S_READY: begin
                    if (stall_i) begin
                        // Frozen pipeline: ID re-asserts any redirect later.
                        r_state <= S_READY;
                    end else if (redirect_i) begin
                        r_pc          <= w_target;
                        r_req         <= 1'b1;
                        r_req_addr    <= w_target;
                        r_fetch_stall <= 1'b1;
                        r_state       <= S_FETCH;
                    end else if (hd_i) begin
                        r_state <= S_READY;
                    end else begin
                        r_pc          <= w_pc_plus4;
                        r_fetch_stall <= 1'b1;
                        if (start_i) begin
                            r_req      <= 1'b1;
                            r_req_addr <= w_pc_plus4;
                            r_state    <= S_FETCH;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end

                default: begin
                    r_state       <= S_IDLE;
                    r_req         <= 1'b0;
                    r_fetch_stall <= 1'b1;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    // Request line must track the states that own an outstanding request.
    a_req_state : assert property (@(posedge clk_i) disable iff (!rst_i)
        imem_req_o == (r_state == S_FETCH || r_state == S_DISCARD));

    // Valid instruction is presented exactly in READY.
    a_stall_state : assert property (@(posedge clk_i) disable iff (!rst_i)
        fetch_stall_o == (r_state != S_READY));

    a_pc_aligned : assert property (@(posedge clk_i) disable iff (!rst_i)
        r_pc[1:0] == 2'b00);
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_unit
//
// Directed, self-checking bench for if_fetch_unit. Inputs change and outputs
// are sampled 1 ns after each rising edge. Expected values are hand-derived
// from the fetch-stage behaviour.
// -----------------------------------------------------------------------------
module tb_if_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        hd_i;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_addr_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;
    logic [31:0] instr_o;
    logic [31:0] addr_o;
    logic        fetch_stall_o;

    int n_cmp = 0;
    int n_bad = 0;

    if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .start_i         (start_i),
        .hd_i            (hd_i),
        .stall_i         (stall_i),
        .redirect_i      (redirect_i),
        .redirect_addr_i (redirect_addr_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_ack_i      (imem_ack_i),
        .imem_data_i     (imem_data_i),
        .instr_o         (instr_o),
        .addr_o          (addr_o),
        .fetch_stall_o   (fetch_stall_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Single-cycle memory response, then back to idle bus.
    task automatic ack(input logic [31:0] d);
        imem_ack_i  = 1'b1;
        imem_data_i = d;
        step();
        imem_ack_i  = 1'b0;
        imem_data_i = 32'h0;
    endtask

    task automatic test_reset();
        rst_i = 1'b0; start_i = 1'b0; hd_i = 1'b0; stall_i = 1'b0;
        redirect_i = 1'b0; redirect_addr_i = 32'h0;
        imem_ack_i = 1'b0; imem_data_i = 32'h0;
        step(); step();
        if (imem_req_o !== 1'b0) begin $display("FAIL reset_req: got %0b want 0", imem_req_o); n_bad++; end n_cmp++;
        if (instr_o !== 32'h0) begin $display("FAIL reset_instr: got %h want 00000000", instr_o); n_bad++; end n_cmp++;
        if (addr_o !== 32'h0) begin $display("FAIL reset_addr: got %h want 00000000", addr_o); n_bad++; end n_cmp++;
        if (fetch_stall_o !== 1'b1) begin $display("FAIL reset_stall: got %0b want 1", fetch_stall_o); n_bad++; end n_cmp++;
        rst_i = 1'b1;
        step();
        if (imem_req_o !== 1'b0) begin $display("FAIL idle_no_start_req: got %0b want 0", imem_req_o); n_bad++; end n_cmp++;
    endtask

    task automatic test_first_fetch();
        start_i = 1'b1;
        step();
        if (imem_req_o !== 1'b1) begin $display("FAIL first_req: got %0b want 1", imem_req_o); n_bad++; end n_cmp++;
        if (imem_addr_o !== 32'h0) begin $display("FAIL first_req_addr: got %h want 00000000", imem_addr_o); n_bad++; end n_cmp++;
        ack(32'h2002_0005);
        if (instr_o !== 32'h2002_0005) begin $display("FAIL first_instr: got %h want 20020005", instr_o); n_bad++; end n_cmp++;
        if (addr_o !== 32'h4) begin $display("FAIL first_addr: got %h want 00000004", addr_o); n_bad++; end n_cmp++;
        if (fetch_stall_o !== 1'b0) begin $display("FAIL first_stall: got %0b want 0", fetch_stall_o); n_bad++; end n_cmp++;
        if (imem_req_o !== 1'b0) begin $display("FAIL ready_req_low: got %0b want 0", imem_req_o); n_bad++; end n_cmp++;
        step();
        if (imem_addr_o !== 32'h4) begin $display("FAIL second_req_addr: got %h want 00000004", imem_addr_o); n_bad++; end n_cmp++;
        if (fetch_stall_o !== 1'b1) begin $display("FAIL second_stall: got %0b want 1", fetch_stall_o); n_bad++; end n_cmp++;
        if (instr_o !== 32'h2002_0005) begin $display("FAIL instr_hold_in_fetch: got %h want 20020005", instr_o); n_bad++; end n_cmp++;
    endtask

    task automatic test_hazard();
        // Walk the PC from 0x4 up to 0x10.
        for (int i = 0; i < 3; i++) begin
            ack(32'h1000_0000 | (32'(i + 1) << 2));
            step();
        end
        if (imem_addr_o !== 32'h10) begin $display("FAIL hd_pre_addr: got %h want 00000010", imem_addr_o); n_bad++; end n_cmp++;
        hd_i = 1'b1;
        ack(32'hAAAA_0010);
        for (int c = 0; c < 3; c++) begin
            if (instr_o !== 32'hAAAA_0010) begin $display("FAIL hd_instr[%0d]: got %h want aaaa0010", c, instr_o); n_bad++; end n_cmp++;
            if (addr_o !== 32'h14) begin $display("FAIL hd_addr[%0d]: got %h want 00000014", c, addr_o); n_bad++; end n_cmp++;
            if (imem_req_o !== 1'b0) begin $display("FAIL hd_req[%0d]: got %0b want 0", c, imem_req_o); n_bad++; end n_cmp++;
            if (fetch_stall_o !== 1'b0) begin $display("FAIL hd_stall[%0d]: got %0b want 0", c, fetch_stall_o); n_bad++; end n_cmp++;
            if (c < 2) step();
        end
        hd_i = 1'b0;
        step();
        if (imem_req_o !== 1'b1) begin $display("FAIL hd_release_req: got %0b want 1", imem_req_o); n_bad++; end n_cmp++;
        if (imem_addr_o !== 32'h14) begin $display("FAIL hd_release_addr: got %h want 00000014", imem_addr_o); n_bad++; end n_cmp++;
    endtask

    task automatic test_redirect_discard();
        ack(32'hBBBB_0014);
        // Redirect from READY to 0x8 (also while hd_i would be irrelevant).
        redirect_i = 1'b1; redirect_addr_i = 32'h8;
        step();
        if (imem_addr_o !== 32'h8) begin $display("FAIL ready_redirect_addr: got %h want 00000008", imem_addr_o); n_bad++; end n_cmp++;
        // Second redirect while 0x8 is outstanding.
        redirect_addr_i = 32'h40;
        step();
        redirect_i = 1'b0;
        for (int c = 0; c < 2; c++) begin
            if (imem_req_o !== 1'b1) begin $display("FAIL discard_req[%0d]: got %0b want 1", c, imem_req_o); n_bad++; end n_cmp++;
            if (imem_addr_o !== 32'h8) begin $display("FAIL discard_addr[%0d]: got %h want 00000008", c, imem_addr_o); n_bad++; end n_cmp++;
            if (fetch_stall_o !== 1'b1) begin $display("FAIL discard_stall[%0d]: got %0b want 1", c, fetch_stall_o); n_bad++; end n_cmp++;
            step();
        end
        ack(32'hDEAD_BEEF);
        if (imem_addr_o !== 32'h40) begin $display("FAIL post_discard_addr: got %h want 00000040", imem_addr_o); n_bad++; end n_cmp++;
        if (instr_o !== 32'hBBBB_0014) begin $display("FAIL discard_data_dropped: got %h want bbbb0014", instr_o); n_bad++; end n_cmp++;
        if (fetch_stall_o !== 1'b1) begin $display("FAIL post_discard_stall: got %0b want 1", fetch_stall_o); n_bad++; end n_cmp++;
        ack(32'h1234_0040);
        if (instr_o !== 32'h1234_0040) begin $display("FAIL target_instr: got %h want 12340040", instr_o); n_bad++; end n_cmp++;
        if (addr_o !== 32'h44) begin $display("FAIL target_addr: got %h want 00000044", addr_o); n_bad++; end n_cmp++;
    endtask

    task automatic test_redirect_with_ack();
        step();
        redirect_i = 1'b1; redirect_addr_i = 32'h103;
        ack(32'hCCCC_0044);
        redirect_i = 1'b0;
        if (imem_req_o !== 1'b1) begin $display("FAIL redir_ack_req: got %0b want 1", imem_req_o); n_bad++; end n_cmp++;
        if (imem_addr_o !== 32'h100) begin $display("FAIL redir_ack_addr: got %h want 00000100", imem_addr_o); n_bad++; end n_cmp++;
        if (instr_o !== 32'h1234_0040) begin $display("FAIL redir_ack_dropped: got %h want 12340040", instr_o); n_bad++; end n_cmp++;
        ack(32'h5555_0100);
        if (addr_o !== 32'h104) begin $display("FAIL redir_ack_target_addr: got %h want 00000104", addr_o); n_bad++; end n_cmp++;
    endtask

    task automatic test_stall();
        step();
        if (imem_addr_o !== 32'h104) begin $display("FAIL stall_pre_addr: got %h want 00000104", imem_addr_o); n_bad++; end n_cmp++;
        stall_i = 1'b1;
        ack(32'h6666_0104);
        if (instr_o !== 32'h6666_0104) begin $display("FAIL stall_ack_instr: got %h want 66660104", instr_o); n_bad++; end n_cmp++;
        if (fetch_stall_o !== 1'b0) begin $display("FAIL stall_ack_ready: got %0b want 0", fetch_stall_o); n_bad++; end n_cmp++;
        redirect_i = 1'b1; redirect_addr_i = 32'h200;
        for (int c = 0; c < 2; c++) begin
            step();
            if (addr_o !== 32'h108) begin $display("FAIL stall_hold_addr[%0d]: got %h want 00000108", c, addr_o); n_bad++; end n_cmp++;
            if (imem_req_o !== 1'b0) begin $display("FAIL stall_hold_req[%0d]: got %0b want 0", c, imem_req_o); n_bad++; end n_cmp++;
            if (fetch_stall_o !== 1'b0) begin $display("FAIL stall_hold_stall[%0d]: got %0b want 0", c, fetch_stall_o); n_bad++; end n_cmp++;
        end
        redirect_i = 1'b0; stall_i = 1'b0;
        step();
        if (imem_addr_o !== 32'h108) begin $display("FAIL stall_release_addr: got %h want 00000108", imem_addr_o); n_bad++; end n_cmp++;
    endtask

    task automatic test_wrap();
        redirect_i = 1'b1; redirect_addr_i = 32'hFFFF_FFFE;
        ack(32'hEEEE_0108);
        redirect_i = 1'b0;
        if (imem_addr_o !== 32'hFFFF_FFFC) begin $display("FAIL wrap_req_addr: got %h want fffffffc", imem_addr_o); n_bad++; end n_cmp++;
        ack(32'h7777_FFFC);
        if (addr_o !== 32'h0) begin $display("FAIL wrap_addr: got %h want 00000000", addr_o); n_bad++; end n_cmp++;
        if (instr_o !== 32'h7777_FFFC) begin $display("FAIL wrap_instr: got %h want 7777fffc", instr_o); n_bad++; end n_cmp++;
        step();
        if (imem_addr_o !== 32'h0) begin $display("FAIL wrap_next_req: got %h want 00000000", imem_addr_o); n_bad++; end n_cmp++;
    endtask

    task automatic test_reset_mid_fetch();
        rst_i = 1'b0;
        #1;
        if (imem_req_o !== 1'b0) begin $display("FAIL async_rst_req: got %0b want 0", imem_req_o); n_bad++; end n_cmp++;
        if (instr_o !== 32'h0) begin $display("FAIL async_rst_instr: got %h want 00000000", instr_o); n_bad++; end n_cmp++;
        if (fetch_stall_o !== 1'b1) begin $display("FAIL async_rst_stall: got %0b want 1", fetch_stall_o); n_bad++; end n_cmp++;
        step();
        rst_i = 1'b1; start_i = 1'b0;
        ack(32'hBAD0_BAD0);
        if (imem_req_o !== 1'b0) begin $display("FAIL late_ack_req: got %0b want 0", imem_req_o); n_bad++; end n_cmp++;
        if (instr_o !== 32'h0) begin $display("FAIL late_ack_instr: got %h want 00000000", instr_o); n_bad++; end n_cmp++;
        if (fetch_stall_o !== 1'b1) begin $display("FAIL late_ack_stall: got %0b want 1", fetch_stall_o); n_bad++; end n_cmp++;
    endtask

    task automatic test_start_low();
        start_i = 1'b1;
        step();
        if (imem_addr_o !== 32'h0) begin $display("FAIL restart_addr: got %h want 00000000", imem_addr_o); n_bad++; end n_cmp++;
        start_i = 1'b0;
        ack(32'h8888_0000);
        if (instr_o !== 32'h8888_0000) begin $display("FAIL start_low_instr: got %h want 88880000", instr_o); n_bad++; end n_cmp++;
        if (addr_o !== 32'h4) begin $display("FAIL start_low_addr: got %h want 00000004", addr_o); n_bad++; end n_cmp++;
        step();
        if (imem_req_o !== 1'b0) begin $display("FAIL idle_after_advance_req: got %0b want 0", imem_req_o); n_bad++; end n_cmp++;
        if (fetch_stall_o !== 1'b1) begin $display("FAIL idle_after_advance_stall: got %0b want 1", fetch_stall_o); n_bad++; end n_cmp++;
        if (instr_o !== 32'h8888_0000) begin $display("FAIL idle_instr_hold: got %h want 88880000", instr_o); n_bad++; end n_cmp++;
        step();
        if (imem_req_o !== 1'b0) begin $display("FAIL idle_stays_req: got %0b want 0", imem_req_o); n_bad++; end n_cmp++;
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_hazard();
        test_redirect_discard();
        test_redirect_with_ack();
        test_stall();
        test_wrap();
        test_reset_mid_fetch();
        test_start_low();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
